ram_mp: RTL and testbench

- Next-generation main memory for the Tinker core: byte-addressed, parametrised width and depth, one read/write port plus NUM_R_PORTS read-only ports (fetch, debug).
- Adds sub-word accesses (1/2/4/8 B) with byte-lane writes, alignment and range error reporting, and registered 1-cycle reads.
- Adds a sequential zero-initialisation sweep after reset.
- Sits between the core's fetch/LSU stages and nothing below; it is the backing store.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_mp_if.sv | 36 +++
 rtl/ram_lane_align.sv | 40 ++++
 rtl/ram_mp.sv | 136 +++++++++++++
 tb/tb_ram_mp.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_mp backing store: access sizes,
// init FSM states and byte-lane mask generation.
package ram_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} access_size_e;
  typedef enum logic {INIT, RUN} init_state_e;

  localparam int MAX_BYTES = 8;

  function automatic logic [3:0] size_bytes(access_size_e size);
    return 4'd1 << size;
  endfunction

  // Lanes touched by an access of 'size' starting at 'lane', clipped to the word.
  function automatic logic [MAX_BYTES-1:0] lane_mask(access_size_e size, logic [2:0] lane,
                                                     int unsigned bytes);
    logic [MAX_BYTES-1:0] m;
    logic [MAX_BYTES-1:0] limit;
    m     = MAX_BYTES'((16'd1 << size_bytes(size)) - 16'd1);
    m     = m << lane;
    limit = (bytes >= MAX_BYTES) ? '1 : MAX_BYTES'((1 << bytes) - 1);
    return m & limit;
  endfunction

endpackage

// File: rtl/ram_mp_if.sv
// Request/response bundle of ram_mp: NUM_R_PORTS read-only ports plus one
// read/write port, flattened per-port vectors as the core expects them.
interface ram_mp_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_R_PORTS = 1
);
  logic                              init_done;

  logic [NUM_R_PORTS-1:0]            r_valid;
  logic [NUM_R_PORTS*ADDR_WIDTH-1:0] r_addr;
  logic [NUM_R_PORTS-1:0]            r_resp_valid;
  logic [NUM_R_PORTS*DATA_WIDTH-1:0] r_data_out;
  logic [NUM_R_PORTS-1:0]            r_error;

  logic                              rw_valid;
  logic                              rw_write_en;
  logic [1:0]                        rw_size;
  logic [ADDR_WIDTH-1:0]             rw_addr;
  logic [DATA_WIDTH-1:0]             rw_data_in;
  logic                              rw_resp_valid;
  logic [DATA_WIDTH-1:0]             rw_data_out;
  logic                              rw_error;

  modport master (
    output r_valid, r_addr, rw_valid, rw_write_en, rw_size, rw_addr, rw_data_in,
    input  init_done, r_resp_valid, r_data_out, r_error,
           rw_resp_valid, rw_data_out, rw_error
  );

  modport slave (
    input  r_valid, r_addr, rw_valid, rw_write_en, rw_size, rw_addr, rw_data_in,
    output init_done, r_resp_valid, r_data_out, r_error,
           rw_resp_valid, rw_data_out, rw_error
  );
endinterface

// File: rtl/ram_lane_align.sv
// Sub-word steering for the rw port: write byte-mask and shifted data,
// right-aligned zero-extended read data, and alignment/size error.
module ram_lane_align
  import ram_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(BYTES)
) (
  input  access_size_e          size,
  input  logic [OFF_W-1:0]      lane,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [BYTES-1:0]      wmask,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  align_err
);
  logic [3:0]            nbytes;
  logic [MAX_BYTES-1:0]  mask_full;
  logic [DATA_WIDTH-1:0] rshift;

  assign nbytes    = size_bytes(size);
  assign mask_full = lane_mask(size, 3'(lane), BYTES);
  assign wmask     = mask_full[BYTES-1:0];
  assign wdata_sh  = wdata << {lane, 3'b000};
  assign rshift    = rword >> {lane, 3'b000};

  // Oversized accesses are flagged here too, so the top sees one error bit.
  assign align_err = (nbytes > 4'(BYTES)) || (|(4'(lane) & (nbytes - 4'd1)));

  always_comb begin
    // NOTE: assign a default before the conditional writes so no latch is inferred.
    rdata = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (4'(b) < nbytes) rdata[b*8 +: 8] = rshift[b*8 +: 8];
    end
  end

endmodule

// File: rtl/ram_mp.sv
// Tinker main memory: byte-addressed array with one rw port and NUM_R_PORTS
// read ports, zero sweep after reset, registered 1-cycle responses.
module ram_mp
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_WORDS = 65536,
  parameter int NUM_R_PORTS = 1
) (
  input logic     clk,
  input logic     reset,
  ram_mp_if.slave bus
);
  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(BYTES);
  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int TOP_LSB = OFF_W + IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  init_state_e      state;
  logic [IDX_W-1:0] sweep_idx;
  logic             accept;

  assign accept = (state == RUN);

  // Any address bit at or above the array span means out of range.
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return |(addr >> TOP_LSB);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= INIT;
      sweep_idx     <= '0;
      bus.init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == IDX_W'(DEPTH_WORDS - 1)) begin
            state         <= RUN;
            bus.init_done <= 1'b1;
          end
        end
        RUN: ;
      endcase
    end
  end

  // rw port decode
  access_size_e          rw_size;
  logic [IDX_W-1:0]      rw_idx;
  logic [BYTES-1:0]      rw_wmask;
  logic [DATA_WIDTH-1:0] rw_wdata;
  logic [DATA_WIDTH-1:0] rw_word;
  logic [DATA_WIDTH-1:0] rw_rdata;
  logic                  rw_align_err;
  logic                  rw_err;
  logic                  rw_fire;
  logic                  rw_wr;

  assign rw_size = access_size_e'(bus.rw_size);
  assign rw_idx  = bus.rw_addr[OFF_W +: IDX_W];
  assign rw_word = mem[rw_idx];
  assign rw_err  = out_of_range(bus.rw_addr) || rw_align_err;
  assign rw_fire = accept && bus.rw_valid;
  assign rw_wr   = rw_fire && bus.rw_write_en && !rw_err;

  ram_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size      (rw_size),
    .lane      (bus.rw_addr[OFF_W-1:0]),
    .wdata     (bus.rw_data_in),
    .rword     (rw_word),
    .wmask     (rw_wmask),
    .wdata_sh  (rw_wdata),
    .rdata     (rw_rdata),
    .align_err (rw_align_err)
  );

  // NOTE: the array has no reset; the post-reset sweep clears it one word per cycle.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[sweep_idx] <= '0;
    end else if (rw_wr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (rw_wmask[b]) mem[rw_idx][b*8 +: 8] <= rw_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rw_resp_valid <= 1'b0;
      bus.rw_error      <= 1'b0;
      bus.rw_data_out   <= '0;
    end else begin
      bus.rw_resp_valid <= rw_fire;
      bus.rw_error      <= rw_fire && rw_err;
      if (rw_fire) bus.rw_data_out <= (rw_err || bus.rw_write_en) ? '0 : rw_rdata;
    end
  end

  // Read ports: full-word only, so any nonzero lane is an error.
  logic [IDX_W-1:0] r_idx [NUM_R_PORTS];
  logic             r_err [NUM_R_PORTS];

  always_comb begin : r_decode
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    for (int p = 0; p < NUM_R_PORTS; p++) begin
      a        = bus.r_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      r_idx[p] = a[OFF_W +: IDX_W];
      r_err[p] = out_of_range(a) || (|a[OFF_W-1:0]);
    end
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.r_resp_valid <= '0;
      bus.r_error      <= '0;
      bus.r_data_out   <= '0;
    end else begin
      for (int p = 0; p < NUM_R_PORTS; p++) begin
        bus.r_resp_valid[p] <= accept && bus.r_valid[p];
        bus.r_error[p]      <= accept && bus.r_valid[p] && r_err[p];
        if (accept && bus.r_valid[p])
          bus.r_data_out[p*DATA_WIDTH +: DATA_WIDTH] <= r_err[p] ? '0 : mem[r_idx[p]];
      end
    end
  end

endmodule

// File: tb/tb_ram_mp.sv
// Self-checking bench for ram_mp: byte-level behavioural model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ram_mp;
  localparam int AW        = 64;
  localparam int DW        = 64;
  localparam int DEPTH     = 16;
  localparam int NR        = 2;
  localparam int BYTES     = DW / 8;
  localparam int MEM_BYTES = DEPTH * BYTES;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_R_PORTS(NR)) bus ();

  ram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .NUM_R_PORTS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: memory as a flat byte array, readiness as a cycle count.
  logic [7:0]    mem_m [MEM_BYTES];
  bit            ready_m = 1'b0;
  int            cyc_m   = 0;
  logic          exp_done = 1'b0;
  logic [NR-1:0] exp_rv   = '0;
  logic [NR-1:0] exp_re   = '0;
  logic [63:0]   exp_rd [NR];
  logic          exp_rwv  = 1'b0;
  logic          exp_rwe  = 1'b0;
  logic [63:0]   exp_rwd  = '0;

  function automatic logic [63:0] read_bytes(longint unsigned a, int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = mem_m[int'(a) + i];
    return v;
  endfunction

  always @(posedge clk) begin : model
    longint unsigned a;
    int              n;
    bit              err;
    if (!reset) begin
      ready_m = 1'b0; cyc_m = 0; exp_done = 1'b0;
      exp_rv = '0; exp_re = '0; exp_rwv = 1'b0; exp_rwe = 1'b0; exp_rwd = '0;
      for (int p = 0; p < NR; p++) exp_rd[p] = '0;
    end else if (!ready_m) begin
      exp_rv = '0; exp_re = '0; exp_rwv = 1'b0; exp_rwe = 1'b0;
      cyc_m++;
      if (cyc_m == DEPTH) begin
        ready_m = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;
      end
    end else begin
      for (int p = 0; p < NR; p++) begin
        exp_rv[p] = bus.r_valid[p];
        exp_re[p] = 1'b0;
        if (bus.r_valid[p]) begin
          a = bus.r_addr[p*AW +: AW];
          err = (a >= MEM_BYTES) || (a % BYTES != 0);
          exp_re[p] = err;
          exp_rd[p] = err ? 64'h0 : read_bytes(a, BYTES);
        end
      end
      exp_rwv = bus.rw_valid;
      exp_rwe = 1'b0;
      if (bus.rw_valid) begin
        a = bus.rw_addr;
        n = 1 << bus.rw_size;
        err = (a >= MEM_BYTES) || (a % n != 0) || (n > BYTES);
        exp_rwe = err;
        exp_rwd = (err || bus.rw_write_en) ? 64'h0 : read_bytes(a, n);
        if (!err && bus.rw_write_en)
          for (int i = 0; i < n; i++) mem_m[int'(a) + i] = bus.rw_data_in[i*8 +: 8];
      end
    end
    exp_done = ready_m;
  end

  // Every cycle: outputs against the model (all zero while reset is low).
  always @(negedge clk) begin : compare
    check("init_done", 64'(bus.init_done), reset ? 64'(exp_done) : 64'h0);
    check("rw_resp_valid", 64'(bus.rw_resp_valid), reset ? 64'(exp_rwv) : 64'h0);
    check("rw_error", 64'(bus.rw_error), reset ? 64'(exp_rwe) : 64'h0);
    check("rw_data_out", bus.rw_data_out, reset ? exp_rwd : 64'h0);
    for (int p = 0; p < NR; p++) begin
      check($sformatf("r%0d_resp_valid", p), 64'(bus.r_resp_valid[p]), reset ? 64'(exp_rv[p]) : 64'h0);
      check($sformatf("r%0d_error", p), 64'(bus.r_error[p]), reset ? 64'(exp_re[p]) : 64'h0);
      check($sformatf("r%0d_data_out", p), bus.r_data_out[p*DW +: DW], reset ? exp_rd[p] : 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.r_valid     = '0;
    bus.rw_valid    = 1'b0;
    bus.rw_write_en = 1'b0;
  endtask

  task automatic rd(input int p, input logic [63:0] a);
    bus.r_valid[p]           = 1'b1;
    bus.r_addr[p*AW +: AW]   = a;
  endtask

  task automatic rw(input bit we, input int sz, input logic [63:0] a, input logic [63:0] d);
    bus.rw_valid    = 1'b1;
    bus.rw_write_en = we;
    bus.rw_size     = 2'(sz);
    bus.rw_addr     = a;
    bus.rw_data_in  = d;
  endtask

  function automatic logic [63:0] rand_addr(input int n);
    case ($urandom_range(0, 9))
      0:       return 64'(MEM_BYTES + $urandom_range(0, 300));
      1:       return {$urandom, $urandom};
      2, 3:    return 64'($urandom_range(0, MEM_BYTES - 1));
      default: return 64'($urandom_range(0, MEM_BYTES / n - 1) * n);
    endcase
  endfunction

  task automatic rand_req();
    int sz;
    for (int p = 0; p < NR; p++) begin
      bus.r_valid[p]         = ($urandom_range(0, 3) != 0);
      bus.r_addr[p*AW +: AW] = rand_addr(BYTES);
    end
    sz = $urandom_range(0, 3);
    rw($urandom_range(0, 1) == 1, sz, rand_addr(1 << sz), {$urandom, $urandom});
    bus.rw_valid = ($urandom_range(0, 3) != 0);
  endtask

  // Bounded wait for init_done with requests thrown at the busy memory.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (bus.init_done !== 1'b1 && n < 100) begin
      rand_req();
      tick();
      n++;
    end
    check(name, 64'(n), 64'(DEPTH));
    idle();
  endtask

  initial begin
    for (int p = 0; p < NR; p++) exp_rd[p] = '0;
    idle();
    bus.r_addr = '0;
    rw(0, 0, 0, 0);
    bus.rw_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // 1: sweep length, then every word reads zero
    wait_init("t1_init_cycles");
    for (int w = 0; w < DEPTH; w++) begin
      idle();
      rd(0, 64'(w * BYTES));
      tick();
      check("t1_zero_data", bus.r_data_out[0 +: DW], 64'h0);
      check("t1_zero_err", 64'(bus.r_error[0]), 64'h0);
    end

    // 2: full-word write then read back
    idle(); rw(1, 3, 64'h10, 64'h1122334455667788); tick();
    check("t2_wr_resp", 64'(bus.rw_resp_valid), 64'h1);
    check("t2_wr_data", bus.rw_data_out, 64'h0);
    idle(); rd(0, 64'h10); tick();
    check("t2_rd", bus.r_data_out[0 +: DW], 64'h1122334455667788);

    // 3: byte write, then full and halfword reads in the same cycle
    idle(); rw(1, 0, 64'h13, 64'hAB); tick();
    idle(); rd(0, 64'h10); rw(0, 1, 64'h12, 64'h0); tick();
    check("t3_word", bus.r_data_out[0 +: DW], 64'h11223344AB667788);
    check("t3_half", bus.rw_data_out, 64'h000000000000AB66);

    // 4: error cases
    idle(); rw(0, 2, 64'h0A, 64'h0); rd(0, 64'h80); rd(1, 64'h04); tick();
    check("t4_rw_err", 64'(bus.rw_error), 64'h1);
    check("t4_rw_data", bus.rw_data_out, 64'h0);
    check("t4_r0_err", 64'(bus.r_error[0]), 64'h1);
    check("t4_r0_data", bus.r_data_out[0 +: DW], 64'h0);
    check("t4_r1_err", 64'(bus.r_error[1]), 64'h1);
    check("t4_r1_data", bus.r_data_out[DW +: DW], 64'h0);
    idle(); rw(1, 2, 64'h0A, 64'hFFFFFFFF); tick();
    check("t4_wr_err", 64'(bus.rw_error), 64'h1);
    idle(); rd(0, 64'h08); rd(1, 64'h10); tick();
    check("t4_unchanged_08", bus.r_data_out[0 +: DW], 64'h0);
    check("t4_unchanged_10", bus.r_data_out[DW +: DW], 64'h11223344AB667788);

    // 5: read-before-write on the same word
    idle(); rw(1, 1, 64'h20, 64'hDEAD); rd(1, 64'h20); tick();
    check("t5_old", bus.r_data_out[DW +: DW], 64'h0);
    idle(); rd(1, 64'h20); tick();
    check("t5_new", bus.r_data_out[DW +: DW], 64'h000000000000DEAD);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_req();
      tick();
    end

    // 6: async reset from RUN, then reset mid-sweep
    idle(); rw(1, 3, 64'h18, 64'hCAFEF00D12345678); tick();
    idle(); rw(0, 3, 64'h18, 64'h0); tick();
    check("t6_pre", bus.rw_data_out, 64'hCAFEF00D12345678);
    idle();
    reset = 1'b0;
    #1;
    check("t6_async_rw_data", bus.rw_data_out, 64'h0);
    check("t6_async_init_done", 64'(bus.init_done), 64'h0);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rand_req();
      tick();
    end
    check("t6_mid_init", 64'(bus.init_done), 64'h0);
    idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    wait_init("t6_init_cycles");
    rd(0, 64'h18); tick();
    check("t6_swept", bus.r_data_out[0 +: DW], 64'h0);
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
